// File: rtl/sbi_pkg.sv
// Shared definitions for the Simple Burst Interface (SBI) initiator and responder.
//   sbi_init_state_e : initiator FSM state encoding
//   SBI_WIDTH        : default data width in bits
//   SBI_DEPTH        : default responder address space in words
//   SBI_MAX_BURST    : default maximum beats per command
package sbi_pkg;

  localparam int SBI_WIDTH     = 32;
  localparam int SBI_DEPTH     = 256;
  localparam int SBI_MAX_BURST = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BURST = 2'd2,
    DRAIN = 2'd3
  } sbi_init_state_e;

endpackage

// File: rtl/sbi_initiator.sv
// SBI initiator: converts one burst command into a bSTART address phase
// followed by bACCESS beats. Write data comes from a valid/ready source and
// read data is registered and handed to a sink that cannot backpressure.
//
// Ports
//   bCLK, bRSTn                    clock, async active-low reset
//   cmd_valid/ready/write/addr/len burst command (len = beats - 1)
//   wdata_valid/ready, wdata       write data source
//   rdata_o, rvalid_o              read data to sink (bQ/bVALID delayed one cycle)
//   done_o                         one-cycle pulse when a command completes
//   err_o                          one-cycle pulse when a command is rejected
//   bADDR, bSTART, bACCESS, bWRITE, bD, bQ, bVALID   SBI bus
//
// Build option
//   SBI_INITIATOR_BOUNDCHK_EN : reject commands whose burst runs past Depth
//   (err_o pulses, no bus activity). Without it, bursts wrap modulo Depth
//   and err_o is tied low.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// START | one-cycle address phase (bSTART)
// BURST | issuing beats; write beats follow wdata_valid
// DRAIN | read only: all beats issued, waiting for the remaining bVALIDs
module sbi_initiator
  import sbi_pkg::*;
#(
  parameter int Width    = SBI_WIDTH,
  parameter int Depth    = SBI_DEPTH,
  parameter int MaxBurst = SBI_MAX_BURST,
  localparam int Aw      = $clog2(Depth),
  localparam int Lw      = $clog2(MaxBurst)
) (
  input  logic             bCLK,
  input  logic             bRSTn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [Aw-1:0]    cmd_addr,
  input  logic [Lw-1:0]    cmd_len,
  input  logic             wdata_valid,
  output logic             wdata_ready,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata_o,
  output logic             rvalid_o,
  output logic             done_o,
  output logic             err_o,
  output logic [Aw-1:0]    bADDR,
  output logic             bSTART,
  output logic             bACCESS,
  output logic             bWRITE,
  output logic [Width-1:0] bD,
  input  logic [Width-1:0] bQ,
  input  logic             bVALID
);

  localparam logic [Lw-1:0] LEN_ONE = Lw'(1);

  sbi_init_state_e state;
  logic [Aw-1:0]   addr_r;
  logic [Lw-1:0]   len_r;
  logic [Lw-1:0]   beat_cnt;
  logic [Lw-1:0]   ret_cnt;
  logic            write_r;
  logic            accept;
  logic            reject;
  logic            ret_en;
  logic            ret_last;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid & cmd_ready;

`ifdef SBI_INITIATOR_BOUNDCHK_EN
  // Wide enough that addr + len + 1 can never overflow before the compare.
  localparam int Cw = Aw + Lw + 1;
  logic [Cw-1:0] end_excl;

  assign end_excl = Cw'(cmd_addr) + Cw'(cmd_len) + Cw'(1);
  assign reject   = accept & (end_excl > Cw'(Depth));

  always_ff @(posedge bCLK or negedge bRSTn) begin
    if (!bRSTn) err_o <= 1'b0;
    else        err_o <= reject;
  end
`else
  assign reject = 1'b0;
  assign err_o  = 1'b0;
`endif

  assign bSTART = (state == START);
  assign bADDR  = addr_r;
  assign bWRITE = write_r;

  always_comb begin
    bACCESS = 1'b0;
    if (state == BURST) bACCESS = write_r ? wdata_valid : 1'b1;
  end

  assign wdata_ready = bACCESS & write_r;
  assign bD          = wdata_ready ? wdata : '0;

  // Read returns are counted only while a burst owns the bus; stray bVALID
  // in IDLE (e.g. after an abort) must not leak to the sink.
  assign ret_en   = bVALID & ((state == BURST) | (state == DRAIN));
  assign ret_last = ret_en & ~write_r & (ret_cnt == len_r);

  always_ff @(posedge bCLK or negedge bRSTn) begin
    if (!bRSTn) begin
      state    <= IDLE;
      addr_r   <= '0;
      len_r    <= '0;
      write_r  <= 1'b0;
      beat_cnt <= '0;
      ret_cnt  <= '0;
      done_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (ret_en) ret_cnt <= ret_cnt + LEN_ONE;
      case (state)
        IDLE: begin
          if (accept && !reject) begin
            addr_r   <= cmd_addr;
            len_r    <= cmd_len;
            write_r  <= cmd_write;
            beat_cnt <= cmd_len;
            ret_cnt  <= '0;
            state    <= START;
          end
        end
        START: state <= BURST;
        BURST: begin
          if (bACCESS) begin
            if (beat_cnt == '0) begin
              // A zero-latency responder could return the last word on the
              // last beat itself, so a read may finish straight from BURST.
              if (write_r || ret_last) begin
                state  <= IDLE;
                done_o <= 1'b1;
              end else begin
                state <= DRAIN;
              end
            end else begin
              beat_cnt <= beat_cnt - LEN_ONE;
            end
          end
        end
        DRAIN: begin
          if (ret_last) begin
            state  <= IDLE;
            done_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge bCLK or negedge bRSTn) begin
    if (!bRSTn) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= ret_en;
      if (ret_en) rdata_o <= bQ;
    end
  end

endmodule

// File: tb/tb_sbi_initiator.sv
`timescale 1ns/1ps
module tb_sbi_initiator;

  localparam int W  = 32;
  localparam int D  = 256;
  localparam int AW = 8;
  localparam int LW = 4;

  logic          bCLK = 1'b0;
  logic          bRSTn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          wdata_valid = 1'b0;
  logic [W-1:0]  wdata = '0;
  logic [W-1:0]  bQ = '0;
  logic          bVALID = 1'b0;
  logic          cmd_ready, wdata_ready, rvalid_o, done_o, err_o;
  logic          bSTART, bACCESS, bWRITE;
  logic [W-1:0]  rdata_o, bD;
  logic [AW-1:0] bADDR;

  always #5 bCLK = ~bCLK;

  int cyc = 0;
  always @(posedge bCLK) cyc <= cyc + 1;

  sbi_initiator dut (
    .bCLK(bCLK), .bRSTn(bRSTn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_o(rdata_o), .rvalid_o(rvalid_o), .done_o(done_o), .err_o(err_o),
    .bADDR(bADDR), .bSTART(bSTART), .bACCESS(bACCESS), .bWRITE(bWRITE),
    .bD(bD), .bQ(bQ), .bVALID(bVALID)
  );

  typedef struct { int cyc; logic [W-1:0] val; } exp_t;
  exp_t q_start[$], q_wbeat[$], q_rd[$], q_done[$], q_err[$];
  logic [W-1:0] ref_mem [D];
  logic [W-1:0] wd [16];
  int bub [16];
  int n_checks = 0;
  int n_pass = 0;

  function automatic exp_t mk(input int c, input logic [W-1:0] v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    return e;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  // SBI memory responder: latches address on bSTART, one-cycle read latency.
  logic [W-1:0]  rmem [D];
  logic [AW-1:0] rptr = '0;
  logic          pend_v = 1'b0;
  logic [W-1:0]  pend_q = '0;
  logic          inj_v = 1'b0;

  always @(negedge bCLK) begin
    bVALID = pend_v | inj_v;
    bQ     = pend_q;
    pend_v = 1'b0;
    if (bSTART) rptr = bADDR;
    else if (bACCESS) begin
      if (bWRITE) rmem[rptr] = bD;
      else begin
        pend_v = 1'b1;
        pend_q = rmem[rptr];
      end
      rptr = rptr + 8'd1;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  always @(negedge bCLK) begin
    exp_t e;
    if (bRSTn) begin
      if (bSTART) begin
        chk("start_vs_access", 32'(bACCESS), 32'd0);
        chk("start_expected", 32'(q_start.size() != 0), 32'd1);
        if (q_start.size() != 0) begin
          e = q_start.pop_front();
          chk("start_cycle", e.cyc == cyc ? 32'(cyc) : 32'(cyc), 32'(e.cyc));
          chk("start_addr_dir", {23'd0, bWRITE, bADDR}, e.val);
        end
      end
      if (bACCESS && bWRITE) begin
        chk("wbeat_ready", 32'(wdata_ready), 32'd1);
        chk("wbeat_expected", 32'(q_wbeat.size() != 0), 32'd1);
        if (q_wbeat.size() != 0) begin
          e = q_wbeat.pop_front();
          chk("wbeat_cycle", 32'(cyc), 32'(e.cyc));
          chk("wbeat_data", bD, e.val);
        end
      end
      if (rvalid_o) begin
        chk("rvalid_expected", 32'(q_rd.size() != 0), 32'd1);
        if (q_rd.size() != 0) begin
          e = q_rd.pop_front();
          chk("rvalid_cycle", 32'(cyc), 32'(e.cyc));
          chk("rdata", rdata_o, e.val);
        end
      end
      if (done_o) begin
        chk("done_expected", 32'(q_done.size() != 0), 32'd1);
        if (q_done.size() != 0) begin
          e = q_done.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (err_o) begin
        chk("err_expected", 32'(q_err.size() != 0), 32'd1);
        if (q_err.size() != 0) begin
          e = q_err.pop_front();
          chk("err_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic tick();
    @(posedge bCLK);
    #1;
  endtask

  // Issues one command, pushes its expected bus/return events, and drives its
  // write data. Returns in the cycle after the last write beat (writes) or
  // in the cycle after acceptance (reads/rejects).
  task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] l, output int t);
    int n, c, k;
    logic bad;
    n = int'(l) + 1;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_len   = l;
    k = 0;
    while (!cmd_ready && k < 300) begin
      tick();
      k++;
    end
    chk("cmd_accept", 32'(cmd_ready), 32'd1);
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      t = -1;
      return;
    end
    t = cyc;
    bad = 1'b0;
`ifdef SBI_INITIATOR_BOUNDCHK_EN
    bad = (int'(a) + n > D);
`endif
    if (bad) q_err.push_back(mk(t + 1, '0));
    else begin
      q_start.push_back(mk(t + 1, {23'd0, wr, a}));
      c = t + 2;
      for (int i = 0; i < n; i++) begin
        if (wr) begin
          c += bub[i];
          q_wbeat.push_back(mk(c, wd[i]));
          ref_mem[(int'(a) + i) % D] = wd[i];
          c++;
        end else begin
          q_rd.push_back(mk(t + 4 + i, ref_mem[(int'(a) + i) % D]));
        end
      end
      q_done.push_back(mk(wr ? c : t + n + 3, '0));
    end
    tick();
    cmd_valid = 1'b0;
    if (bad) chk("reject_ready", 32'(cmd_ready), 32'd1);
    else if (wr) begin
      wdata_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
        for (int b = 0; b < bub[i]; b++) begin
          tick();
          wdata_valid = 1'b0;
          wdata = $urandom;
        end
        tick();
        wdata_valid = 1'b1;
        wdata = wd[i];
      end
      tick();
      wdata_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((q_start.size() + q_wbeat.size() + q_rd.size() + q_done.size() + q_err.size()) != 0 && k < 400) begin
      tick();
      k++;
    end
    chk("drain_queues", 32'(q_start.size() + q_wbeat.size() + q_rd.size() + q_done.size() + q_err.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_ctrl"}, 32'({bSTART, bACCESS, wdata_ready, rvalid_o, done_o, err_o}), 32'd0);
    chk({tag, "_bus"}, 32'({bWRITE, bADDR}), 32'd0);
    chk({tag, "_data"}, rdata_o | bD, 32'd0);
  endtask

  task automatic set_data(input logic [W-1:0] base);
    for (int i = 0; i < 16; i++) begin
      wd[i]  = base + 32'(i);
      bub[i] = 0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t1, t2;
    for (int i = 0; i < D; i++) begin
      rmem[i]    = 32'h5A00_0000 | 32'(i);
      ref_mem[i] = 32'h5A00_0000 | 32'(i);
    end
    repeat (3) tick();
    check_idle_outputs("reset");
    bRSTn = 1'b1;
    tick();

    // Plain 4-beat write, then read it back.
    set_data(32'hA0);
    send_cmd(1'b1, 8'h10, 4'd3, t1);
    wait_idle();
    send_cmd(1'b0, 8'h10, 4'd3, t1);
    wait_idle();

    // 2-cycle wdata_valid gap before the third beat.
    set_data(32'hB0);
    bub[2] = 2;
    send_cmd(1'b1, 8'h20, 4'd3, t1);
    wait_idle();
    send_cmd(1'b0, 8'h20, 4'd3, t1);
    wait_idle();

    // Fill the top and bottom of memory, then read across the wrap.
    set_data(32'hC0);
    send_cmd(1'b1, 8'hFC, 4'd3, t1);
    wait_idle();
    set_data(32'hD0);
    send_cmd(1'b1, 8'h00, 4'd1, t1);
    wait_idle();
    send_cmd(1'b0, 8'hFE, 4'd3, t1);
    wait_idle();

    // Abort a read mid-burst; a later stray bVALID must be ignored.
    send_cmd(1'b0, 8'h40, 4'd7, t1);
    tick();
    tick();
    #2 bRSTn = 1'b0;
    #1;
    check_idle_outputs("abort");
    q_rd.delete();
    q_done.delete();
    tick();
    tick();
    bRSTn = 1'b1;
    inj_v = 1'b1;
    tick();
    inj_v = 1'b0;
    repeat (4) begin
      tick();
      chk("abort_quiet", 32'({rvalid_o, done_o}), 32'd0);
    end

    // Back-to-back: next command accepted in the done cycle of the previous.
    set_data(32'hE0);
    send_cmd(1'b0, 8'h10, 4'd3, t1);
    send_cmd(1'b1, 8'h60, 4'd1, t2);
    chk("b2b_read_then_write", 32'(t2), 32'(t1 + 7));
    send_cmd(1'b0, 8'h60, 4'd1, t1);
    chk("b2b_write_then_read", 32'(t1), 32'(t2 + 4));
    wait_idle();

    for (int k = 0; k < 40; k++) begin
      logic          wr;
      logic [AW-1:0] a;
      logic [LW-1:0] l;
      wr = 1'($urandom_range(0, 1));
      a  = 8'($urandom);
      l  = 4'($urandom);
      for (int i = 0; i < 16; i++) begin
        wd[i]  = $urandom;
        bub[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      end
      send_cmd(wr, a, l, t1);
      if ($urandom_range(0, 1) == 0) begin
        wait_idle();
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
